ttt_move_judge: RTL and testbench

- Producer side of the per-game win pulse consumed by the 3-bit win counter.
- Holds the 3x3 board and accepts one move per handshake from the input/FSM layer.
- Alternates players and detects three-in-a-row or a full board.
- Emits exactly one single-cycle win_x/win_o/draw pulse per game.

---
 rtl/ttt_pkg.sv | 35 +++
 rtl/ttt_line_check.sv | 26 ++
 rtl/ttt_move_judge.sv | 130 +++++++++++++
 tb/tb_ttt_move_judge.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move judge: cell codes,
// judge states and the eight winning lines as triples of cell indices.
package ttt_pkg;

    localparam int NUM_CELLS = 9;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    // Rows, then columns, then the two diagonals, row-major cell numbering.
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic cell_t cell_of(input logic [17:0] brd, input int idx);
        return cell_t'(brd[2*idx +: 2]);
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector for a single player on a packed
// 18-bit board.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic        player,
    output logic        hit
);

    cell_t w_code;

    assign w_code = player ? O : X;

    always_comb begin
        hit = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (cell_of(board, int'(WIN_LINES[l][0])) == w_code &&
                cell_of(board, int'(WIN_LINES[l][1])) == w_code &&
                cell_of(board, int'(WIN_LINES[l][2])) == w_code) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_move_judge.sv
// Tic-tac-toe referee: accepts one move per handshake, alternates players and
// emits exactly one win_x/win_o/draw pulse per game, two edges after the last move.
module ttt_move_judge
    import ttt_pkg::*;
#(
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    output logic        move_ready,
    output logic [17:0] board,
    output logic        turn,
    output logic [3:0]  move_count,
    output logic        win_x,
    output logic        win_o,
    output logic        draw,
    output logic        game_over,
    output logic        illegal
);

    state_t      r_state;
    logic [17:0] r_board;
    logic        r_turn;
    logic [3:0]  r_move_count;
    logic        r_win_x;
    logic        r_win_o;
    logic        r_draw;
    logic        r_game_over;
    logic        r_illegal;

    logic        w_hit;
    logic        w_pos_ok;
    logic        w_target_empty;
    logic [1:0]  w_mark;

    ttt_line_check u_line_check (
        .board  (r_board),
        .player (r_turn),
        .hit    (w_hit)
    );

    assign w_pos_ok = (move_pos <= 4'd8);
    assign w_mark   = r_turn ? O : X;

    // Out-of-range positions never address the board, so the cell read is gated.
    always_comb begin
        w_target_empty = 1'b0;
        if (w_pos_ok) begin
            w_target_empty = (cell_of(r_board, int'(move_pos)) == EMPTY);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= PLAY;
            r_board      <= '0;
            r_turn       <= FIRST_PLAYER;
            r_move_count <= '0;
            r_win_x      <= 1'b0;
            r_win_o      <= 1'b0;
            r_draw       <= 1'b0;
            r_game_over  <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (new_game) begin
            r_state      <= PLAY;
            r_board      <= '0;
            r_turn       <= FIRST_PLAYER;
            r_move_count <= '0;
            r_win_x      <= 1'b0;
            r_win_o      <= 1'b0;
            r_draw       <= 1'b0;
            r_game_over  <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_win_x   <= 1'b0;
            r_win_o   <= 1'b0;
            r_draw    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                PLAY: begin
                    if (move_valid) begin
                        if (w_target_empty) begin
                            r_board[2*int'(move_pos) +: 2] <= w_mark;
                            r_move_count                   <= r_move_count + 4'd1;
                            r_state                        <= CHECK;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                // Only the player who just moved can have completed a line.
                CHECK: begin
                    if (w_hit) begin
                        r_win_x     <= ~r_turn;
                        r_win_o     <= r_turn;
                        r_game_over <= 1'b1;
                        r_state     <= OVER;
                    end else if (r_move_count == 4'd9) begin
                        r_draw      <= 1'b1;
                        r_game_over <= 1'b1;
                        r_state     <= OVER;
                    end else begin
                        r_turn  <= ~r_turn;
                        r_state <= PLAY;
                    end
                end
                OVER: begin
                    r_game_over <= 1'b1;
                end
                default: begin
                    r_state <= PLAY;
                end
            endcase
        end
    end

    assign move_ready = (r_state == PLAY);
    assign board      = r_board;
    assign turn       = r_turn;
    assign move_count = r_move_count;
    assign win_x      = r_win_x;
    assign win_o      = r_win_o;
    assign draw       = r_draw;
    assign game_over  = r_game_over;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_ttt_move_judge.sv
// Scoreboard bench for ttt_move_judge: moves push the expected pulse and its
// cycle into a queue; a negedge monitor pops and compares every pulse it sees.
module tb_ttt_move_judge;

    localparam int K_NONE    = -1;
    localparam int K_WIN_X   = 0;
    localparam int K_WIN_O   = 1;
    localparam int K_DRAW    = 2;
    localparam int K_ILLEGAL = 3;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        new_game;
    logic        move_valid;
    logic [3:0]  move_pos;
    logic        move_ready;
    logic [17:0] board;
    logic        turn;
    logic [3:0]  move_count;
    logic        win_x;
    logic        win_o;
    logic        draw;
    logic        game_over;
    logic        illegal;

    exp_t expQ[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    ttt_move_judge #(.FIRST_PLAYER(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .move_ready (move_ready),
        .board      (board),
        .turn       (turn),
        .move_count (move_count),
        .win_x      (win_x),
        .win_o      (win_o),
        .draw       (draw),
        .game_over  (game_over),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        int n;
        int kind;
        exp_t e;
        n = int'(win_x) + int'(win_o) + int'(draw) + int'(illegal);
        if (n != 0) begin
            checks++;
            kind = win_x ? K_WIN_X : win_o ? K_WIN_O : draw ? K_DRAW : K_ILLEGAL;
            if (n > 1) begin
                failures++;
                $display("[TB] FAIL pulse_onehot cyc=%0d got %0d pulses high, required 1", cyc, n);
            end else if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_pulse cyc=%0d got kind %0d, required none", cyc, kind);
            end else begin
                e = expQ.pop_front();
                if (e.kind != kind || e.cyc != cyc) begin
                    failures++;
                    $display("[TB] FAIL pulse got kind %0d at cyc %0d, required kind %0d at cyc %0d",
                             kind, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Starts and ends #1 after a rising edge; leaves the CHECK cycle elapsed.
    task automatic applyStimulus(input logic [3:0] pos, input int kind);
        exp_t e;
        move_valid = 1'b1;
        move_pos   = pos;
        if (kind != K_NONE) begin
            e.kind = kind;
            e.cyc  = (kind == K_ILLEGAL) ? cyc + 1 : cyc + 2;
            expQ.push_back(e);
        end
        @(posedge clk); #1;
        move_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic newGame();
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        checkOutput("ng_board", 32'(board), 32'h0);
        checkOutput("ng_count", 32'(move_count), 32'h0);
        checkOutput("ng_turn", 32'(turn), 32'h0);
        checkOutput("ng_ready", 32'(move_ready), 32'h1);
        checkOutput("ng_over", 32'(game_over), 32'h0);
    endtask

    initial begin
        reset      = 1'b0;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_pos   = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        checkOutput("rst_board", 32'(board), 32'h0);
        checkOutput("rst_count", 32'(move_count), 32'h0);
        checkOutput("rst_turn", 32'(turn), 32'h0);
        checkOutput("rst_ready", 32'(move_ready), 32'h1);
        checkOutput("rst_over", 32'(game_over), 32'h0);

        // X wins on the top row.
        applyStimulus(4'd0, K_NONE);
        applyStimulus(4'd3, K_NONE);
        applyStimulus(4'd1, K_NONE);
        applyStimulus(4'd4, K_NONE);
        applyStimulus(4'd2, K_WIN_X);
        checkOutput("s1_over", 32'(game_over), 32'h1);
        checkOutput("s1_count", 32'(move_count), 32'h5);
        checkOutput("s1_low6", 32'(board[5:0]), 32'h15);
        checkOutput("s1_ready", 32'(move_ready), 32'h0);
        applyStimulus(4'd6, K_NONE);
        checkOutput("s1_over_board", 32'(board), 32'h00295);
        checkOutput("s1_over_count", 32'(move_count), 32'h5);
        newGame();

        // O wins on the anti-diagonal 2,4,6.
        applyStimulus(4'd0, K_NONE);
        applyStimulus(4'd4, K_NONE);
        applyStimulus(4'd1, K_NONE);
        applyStimulus(4'd2, K_NONE);
        applyStimulus(4'd5, K_NONE);
        applyStimulus(4'd6, K_WIN_O);
        checkOutput("s2_turn", 32'(turn), 32'h1);
        checkOutput("s2_over", 32'(game_over), 32'h1);
        newGame();

        // Full board with no line.
        applyStimulus(4'd0, K_NONE);
        applyStimulus(4'd1, K_NONE);
        applyStimulus(4'd2, K_NONE);
        applyStimulus(4'd4, K_NONE);
        applyStimulus(4'd3, K_NONE);
        applyStimulus(4'd5, K_NONE);
        applyStimulus(4'd7, K_NONE);
        applyStimulus(4'd6, K_NONE);
        applyStimulus(4'd8, K_DRAW);
        checkOutput("s3_count", 32'(move_count), 32'h9);
        checkOutput("s3_over", 32'(game_over), 32'h1);
        newGame();

        // Occupied cell and out-of-range position are rejected.
        applyStimulus(4'd4, K_NONE);
        applyStimulus(4'd4, K_ILLEGAL);
        applyStimulus(4'd12, K_ILLEGAL);
        checkOutput("s4_board", 32'(board), 32'h00100);
        checkOutput("s4_turn", 32'(turn), 32'h1);
        checkOutput("s4_count", 32'(move_count), 32'h1);
        newGame();

        // Async reset while the winning move is in CHECK.
        applyStimulus(4'd0, K_NONE);
        applyStimulus(4'd3, K_NONE);
        applyStimulus(4'd1, K_NONE);
        applyStimulus(4'd4, K_NONE);
        move_valid = 1'b1;
        move_pos   = 4'd2;
        @(posedge clk); #1;
        move_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("ar_board", 32'(board), 32'h0);
        checkOutput("ar_count", 32'(move_count), 32'h0);
        checkOutput("ar_winx", 32'(win_x), 32'h0);
        checkOutput("ar_over", 32'(game_over), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("ar_after_ready", 32'(move_ready), 32'h1);
        checkOutput("ar_after_board", 32'(board), 32'h0);

        // new_game on the same edge as a move drops the move.
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_pos   = 4'd4;
        @(posedge clk); #1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        checkOutput("ngm_board", 32'(board), 32'h0);
        checkOutput("ngm_count", 32'(move_count), 32'h0);
        checkOutput("ngm_ready", 32'(move_ready), 32'h1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(expQ.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
